// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ==========================================================================
// bcd_serial_adder : packed-BCD adder, one decimal digit per clock, LS first.
// Optional BCD_SERIAL_CHECK_EN adds the invalid-nibble flag.     Rev 1.0
// ==========================================================================

module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);
  logic [4:0] w_z;

  always_comb begin
    w_z = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (w_z > 5'd9) begin
      digit = w_z[3:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = w_z[3:0];
      cout  = 1'b0;
    end
  end
endmodule

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [CW-1:0] r_cnt;

  logic [3:0]    w_digit;
  logic          w_carry;
  logic          w_last;
  logic          w_accept;

  bcd_digit_add u_digit (
    .a     (r_a[3:0]),
    .b     (r_b[3:0]),
    .cin   (r_carry),
    .digit (w_digit),
    .cout  (w_carry)
  );

  assign w_last   = (r_cnt == CW'(DIGITS - 1));
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // New digit enters at the top; after DIGITS shifts digit 0 lands at [3:0].
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_sum   <= {w_digit, r_sum[W-1:4]};
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout  <= w_carry;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BCD_SERIAL_CHECK_EN
  logic r_flag;
  logic r_invalid;
  logic w_flag_next;

  assign w_flag_next = r_flag | (r_a[3:0] > 4'd9) | (r_b[3:0] > 4'd9);

  // Sticky across the run, published to invalid only when the result completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag    <= 1'b0;
      r_invalid <= 1'b0;
    end else if (w_accept) begin
      r_flag <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_flag <= w_flag_next;
      if (w_last) begin
        r_invalid <= w_flag_next;
      end
    end
  end

  assign invalid = r_invalid;
`else
  assign invalid = 1'b0;
`endif

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ==========================================================================
// tb_bcd_serial_adder : vector table, corner sequences and random ops
// checked against a decimal-arithmetic model.                    Rev 1.0
// ==========================================================================

module tb_bcd_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Expected {cout, sum} from plain decimal addition modulo 10^4.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    int t = bcd2int(x) + bcd2int(y);
    return {(t >= 10000), int2bcd(t % 10000)};
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, output logic [15:0] rs,
                        output logic rc, output logic ri);
    int n;
    int busy_cnt;
    bit seen;
    a = ta;
    b = tb_;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    busy_cnt = busy ? 1 : 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      chk("busy_done_overlap", busy & done, 0);
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("latency", n, 4);
    chk("busy_cycles", busy_cnt, 4);
    rs = sum;
    rc = cout;
    ri = invalid;
    @(posedge clk); #1;
    chk("done_width", done, 0);
  endtask

  initial begin
    logic [15:0] rs;
    logic        rc;
    logic        ri;
    logic [16:0] m;
    logic [15:0] ha[18];
    logic [15:0] hb[18];
    bit          any_done;

    vt[0] = '{16'h1234, 16'h5678, 16'h6912, 1'b0};
    vt[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1};
    vt[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vt[3] = '{16'h0958, 16'h0047, 16'h1005, 1'b0};
    vt[4] = '{16'h5000, 16'h5000, 16'h0000, 1'b1};
    vt[5] = '{16'h9999, 16'h9999, 16'h9998, 1'b1};
    vt[6] = '{16'h0005, 16'h0005, 16'h0010, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_invalid", invalid, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, rs, rc, ri);
      chk($sformatf("vec%0d_sum", i), rs, vt[i].s);
      chk($sformatf("vec%0d_cout", i), rc, vt[i].c);
      chk($sformatf("vec%0d_invalid", i), ri, 0);
    end

    // start held high with operands changing every cycle
    for (int e = 0; e < 18; e++) begin
      ha[e] = rand_bcd();
      hb[e] = rand_bcd();
      a = ha[e];
      b = hb[e];
      start = 1'b1;
      @(posedge clk); #1;
      if (e % 6 == 4) begin
        m = model(ha[e-4], hb[e-4]);
        chk("hold_done", done, 1);
        chk("hold_sum", sum, m[15:0]);
        chk("hold_cout", cout, m[16]);
      end else begin
        chk("hold_nodone", done, 0);
      end
    end
    start = 1'b0;

    // reset on edge E2 of a run
    a = 16'h1234;
    b = 16'h5678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    any_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) any_done = 1;
    end
    chk("abort_no_done", any_done, 0);
    run_op(16'h0005, 16'h0005, rs, rc, ri);
    chk("after_abort_sum", rs, 16'h0010);
    chk("after_abort_cout", rc, 0);

    // invalid-nibble detection
    run_op(16'h00A0, 16'h0001, rs, rc, ri);
`ifdef BCD_SERIAL_CHECK_EN
    chk("invalid_set", ri, 1);
`else
    chk("invalid_tied", ri, 0);
`endif
    run_op(16'h0001, 16'h0001, rs, rc, ri);
    chk("invalid_clear_sum", rs, 16'h0002);
    chk("invalid_clear", ri, 0);

    for (int k = 0; k < 20; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = rand_bcd();
      rb = rand_bcd();
      m = model(ra, rb);
      run_op(ra, rb, rs, rc, ri);
      chk($sformatf("rand%0d_sum", k), rs, m[15:0]);
      chk($sformatf("rand%0d_cout", k), rc, m[16]);
      chk($sformatf("rand%0d_invalid", k), ri, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
